// File: rtl/gl_pkg.sv
// gl_pkg: shared constants and state type for the matrix stack controller
package gl_pkg;
  localparam logic MODE_MODELVIEW = 1'b0;
  localparam logic MODE_PROJECTION = 1'b1;
  localparam int ROWS_PER_MATRIX = 4;
  localparam int ROW_W = 128;
  typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;
endpackage

// File: rtl/gl_matrix_stack_ctrl.sv
// gl_matrix_stack_ctrl: sequences push/pop of the 4x4 current matrix to/from the stack BRAM
module gl_matrix_stack_ctrl
  import gl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SP_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic             pop_en,
  input  logic             matrix_mode_in,
  output logic             stall,
  output logic             overflow,
  output logic             underflow,
  output logic [SP_W:0]    sp_mv,
  output logic [SP_W:0]    sp_proj,
  output logic [SP_W+2:0]  mem_addr,
  output logic             mem_we,
  output logic [ROW_W-1:0] mem_wdata,
  input  logic [ROW_W-1:0] mem_rdata,
  output logic [1:0]       cur_row_sel,
  input  logic [ROW_W-1:0] cur_row_in,
  output logic             cur_we,
  output logic [ROW_W-1:0] cur_row_out
);
  localparam logic [SP_W:0] FULL = (SP_W+1)'(DEPTH);
  localparam logic [2:0] PUSH_LAST = 3'(ROWS_PER_MATRIX - 1);
  localparam logic [2:0] POP_LAST = 3'(ROWS_PER_MATRIX);
  state_t state, state_n;
  logic [2:0] bcnt;
  logic [SP_W:0] base;
  logic [SP_W:0] sp_sel, sp_dec, sp_nxt;
  logic push_ok, pop_ok, idle;
  logic [1:0] row, row_m1;
  assign idle = state == IDLE;
  assign sp_sel = (matrix_mode_in == MODE_PROJECTION) ? sp_proj : sp_mv;
  assign sp_dec = sp_sel - 1'b1;
  assign push_ok = idle && push_en && sp_sel != FULL;
  assign pop_ok = idle && !push_en && pop_en && sp_sel != '0;
  assign sp_nxt = push_ok ? sp_sel + 1'b1 : sp_dec;
  assign row = bcnt[1:0];
  // pop writes lag reads by one beat to cover the BRAM read latency
  assign row_m1 = row - 2'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (idle) state_n = push_ok ? PUSH : pop_ok ? POP : IDLE;
    else if ((state == PUSH && bcnt == PUSH_LAST) || (state == POP && bcnt == POP_LAST)) state_n = IDLE;
    stall = !idle || push_ok || pop_ok;
    mem_we = state == PUSH;
    mem_addr = (mem_we || (state == POP && bcnt != POP_LAST)) ? {base, row} : '0;
    mem_wdata = mem_we ? cur_row_in : '0;
    cur_we = state == POP && bcnt != 3'd0;
    cur_row_sel = mem_we ? row : cur_we ? row_m1 : 2'd0;
    cur_row_out = cur_we ? mem_rdata : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt <= '0;
      base <= '0;
      sp_mv <= '0;
      sp_proj <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= idle && push_en && sp_sel == FULL;
      underflow <= idle && !push_en && pop_en && sp_sel == '0;
      bcnt <= idle ? 3'd0 : bcnt + 3'd1;
      if (push_ok) base <= {matrix_mode_in, sp_sel[SP_W-1:0]};
      if (pop_ok) base <= {matrix_mode_in, sp_dec[SP_W-1:0]};
      if ((push_ok || pop_ok) && matrix_mode_in == MODE_PROJECTION) sp_proj <= sp_nxt;
      if ((push_ok || pop_ok) && matrix_mode_in == MODE_MODELVIEW) sp_mv <= sp_nxt;
    end
  end
endmodule

// File: tb/tb_gl_matrix_stack_ctrl.sv
// tb_gl_matrix_stack_ctrl: randomized push/pop against a queue-based stack model
module tb_gl_matrix_stack_ctrl;
  localparam int DEPTH = 8;
  localparam int SP_W = 3;
  logic clk = 0, reset = 1, push_en = 0, pop_en = 0, matrix_mode_in = 0;
  logic stall, overflow, underflow, mem_we, cur_we;
  logic [SP_W:0] sp_mv, sp_proj;
  logic [SP_W+2:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata, cur_row_in, cur_row_out;
  logic [1:0] cur_row_sel;
  logic [127:0] bram [64];
  logic [3:0][127:0] cur, ld_m, ref_cur;
  logic ld = 0;
  logic [3:0][127:0] q_mv[$], q_pr[$];
  logic [5:0] wa[$];
  logic [127:0] wd[$];
  int cwe_n = 0;
  int errs = 0, checks = 0;

  gl_matrix_stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push_en(push_en), .pop_en(pop_en),
    .matrix_mode_in(matrix_mode_in), .stall(stall), .overflow(overflow),
    .underflow(underflow), .sp_mv(sp_mv), .sp_proj(sp_proj),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cur_row_sel(cur_row_sel), .cur_row_in(cur_row_in),
    .cur_we(cur_we), .cur_row_out(cur_row_out)
  );

  always #5 clk = ~clk;
  assign cur_row_in = cur[cur_row_sel];

  // environment: stack BRAM with 1-cycle read latency and the current-matrix register file
  always @(posedge clk) begin
    mem_rdata <= bram[mem_addr];
    if (mem_we) bram[mem_addr] <= mem_wdata;
    if (ld) cur <= ld_m;
    else if (cur_we) cur[cur_row_sel] <= cur_row_out;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (cur_we) cwe_n++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0][127:0] rnd_m();
    logic [3:0][127:0] m;
    for (int r = 0; r < 4; r++) m[r] = {$urandom, $urandom, $urandom, $urandom};
    return m;
  endfunction

  task automatic load(input logic [3:0][127:0] m);
    @(negedge clk);
    ld_m = m;
    ld = 1;
    @(negedge clk);
    ld = 0;
    ref_cur = m;
  endtask

  task automatic op(input bit is_push, input bit mode);
    int sp, n, w0, c0;
    bit ok;
    logic [3:0][127:0] m;
    logic [5:0] ea;
    sp = mode ? q_pr.size() : q_mv.size();
    ok = is_push ? (sp < DEPTH) : (sp > 0);
    w0 = wa.size();
    c0 = cwe_n;
    m = ref_cur;
    if (ok && is_push && mode) q_pr.push_back(ref_cur);
    if (ok && is_push && !mode) q_mv.push_back(ref_cur);
    if (ok && !is_push && mode) m = q_pr.pop_back();
    if (ok && !is_push && !mode) m = q_mv.pop_back();
    @(negedge clk);
    push_en = is_push;
    pop_en = !is_push;
    matrix_mode_in = mode;
    #1;
    chk("stall_accept", stall, ok);
    @(negedge clk);
    push_en = 0;
    pop_en = 0;
    matrix_mode_in = 1'($urandom);
    chk("overflow", overflow, is_push && !ok);
    chk("underflow", underflow, !is_push && !ok);
    chk("sp_mv", sp_mv, q_mv.size());
    chk("sp_proj", sp_proj, q_pr.size());
    n = ok ? 1 : 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("stall_len", n, !ok ? 0 : is_push ? 5 : 6);
    @(negedge clk);
    chk("pulse_clr", {overflow, underflow}, 0);
    chk("wr_cnt", wa.size() - w0, (ok && is_push) ? 4 : 0);
    chk("cwe_cnt", cwe_n - c0, (ok && !is_push) ? 4 : 0);
    if (ok && is_push)
      for (int r = 0; r < 4; r++) if (w0 + r < wa.size()) begin
        ea = {mode, 3'(sp), 2'(r)};
        chk("wr_addr", wa[w0+r], ea);
        chk("wr_data", wd[w0+r], ref_cur[r]);
      end
    if (ok && !is_push) begin
      for (int r = 0; r < 4; r++) chk("cur_row", cur[r], m[r]);
      ref_cur = m;
    end
  endtask

  initial begin
    logic [3:0][127:0] m;
    ref_cur = '0;
    ld_m = '0;
    cur = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_sp_mv", sp_mv, 0);
    chk("rst_sp_proj", sp_proj, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cur_we", cur_we, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    reset = 0;
    for (int r = 0; r < 4; r++) m[r] = 128'(r + 1);
    load(m);
    op(1, 0);
    load(rnd_m());
    op(0, 0);
    op(0, 1);
    for (int i = 0; i < 8; i++) begin
      load(rnd_m());
      op(1, 1);
    end
    op(1, 1);
    for (int i = 0; i < 8; i++) op(0, 1);
    op(1, 1);
    op(1, 0);
    // abort a push during its third beat with an asynchronous reset
    @(negedge clk);
    push_en = 1;
    matrix_mode_in = 0;
    @(negedge clk);
    push_en = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_sp_mv", sp_mv, 0);
    chk("mid_rst_sp_proj", sp_proj, 0);
    q_mv.delete();
    q_pr.delete();
    @(negedge clk);
    reset = 0;
    load(rnd_m());
    op(1, 0);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(2) == 0) load(rnd_m());
      op(1'($urandom), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
